// File: rtl/phase_seq_pkg.sv
// Shared constants and helpers for the SimpleRISC multi-phase sequencer.
package phase_seq_pkg;
  localparam int NUM_PHASES_DEF = 5;
  localparam int UPC = 0;
  localparam int RIM = 1;
  localparam int RRF = 2;
  localparam int DM  = 3;
  localparam int WRF = 4;
  localparam logic [NUM_PHASES_DEF-1:0] STALL_MASK_DEF = 5'b00100;

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} seq_state_t;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/phase_sequencer_if.sv
// Control/status bundle between the sequencer and its SimpleRISC datapath host.
interface phase_sequencer_if
  import phase_seq_pkg::*;
#(
  parameter int NUM_PHASES = NUM_PHASES_DEF,
  parameter int CNT_W      = 32
);
  localparam int IW = clog2_min1(NUM_PHASES);

  logic                  run;
  logic                  step;
  logic                  stall;
  logic                  flush;
  logic [NUM_PHASES-1:0] phase_en;
  logic [IW-1:0]         phase_idx;
  logic                  cycle_done;
  logic                  halted;
  logic [CNT_W-1:0]      retired_cnt;
  logic [CNT_W-1:0]      stall_cnt;

  modport master (
    output run, step, stall, flush,
    input  phase_en, phase_idx, cycle_done, halted, retired_cnt, stall_cnt
  );

  modport slave (
    input  run, step, stall, flush,
    output phase_en, phase_idx, cycle_done, halted, retired_cnt, stall_cnt
  );
endinterface

// File: rtl/phase_sequencer_event_counter.sv
// Free-running wrap-around event counter used for debug statistics.
module event_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/phase_sequencer.sv
// Multi-phase instruction-cycle sequencer: one-hot phase enables with stall,
// single-step, halt and flush control plus retired/stall event counters.
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int                    NUM_PHASES = NUM_PHASES_DEF,
  parameter logic [NUM_PHASES-1:0] STALL_MASK = NUM_PHASES'(STALL_MASK_DEF),
  parameter int                    CNT_W      = 32
) (
  input  logic clk,
  input  logic rst,
  phase_sequencer_if.slave bus
);
  localparam int            IW   = clog2_min1(NUM_PHASES);
  localparam logic [IW-1:0] LAST = IW'(NUM_PHASES - 1);

  seq_state_t            state, state_nx;
  logic [IW-1:0]         idx, idx_nx;
  logic [NUM_PHASES-1:0] en_q, en_nx;
  logic                  hold;
  logic                  done;
  logic                  stall_inc;

  assign hold = (state == ACTIVE) && bus.stall && STALL_MASK[idx];

  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    done      = 1'b0;
    stall_inc = 1'b0;
    case (state)
      IDLE: begin
        if (bus.run || bus.step) begin
          state_nx = ACTIVE;
          idx_nx   = '0;
        end
      end
      ACTIVE: begin
        // An aborted cycle restarts or parks exactly like a completed one, minus the retire.
        if (bus.flush) begin
          idx_nx   = '0;
          state_nx = bus.run ? ACTIVE : IDLE;
        end else if (hold) begin
          stall_inc = 1'b1;
        end else if (idx == LAST) begin
          done     = 1'b1;
          idx_nx   = '0;
          state_nx = bus.run ? ACTIVE : IDLE;
        end else begin
          idx_nx = idx + IW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        idx_nx   = '0;
      end
    endcase
    en_nx = (state_nx == ACTIVE) ? (NUM_PHASES'(1) << idx_nx) : '0;
  end

  // Enables are registered from the next-state decode so the datapath sees clean edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
      en_q  <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      en_q  <= en_nx;
    end
  end

  assign bus.phase_en   = en_q;
  assign bus.phase_idx  = idx;
  assign bus.halted     = (state == IDLE);
  assign bus.cycle_done = done;

  event_counter #(.CNT_W(CNT_W)) u_retired (
    .clk (clk),
    .rst (rst),
    .inc (done),
    .cnt (bus.retired_cnt)
  );

  event_counter #(.CNT_W(CNT_W)) u_stalls (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .cnt (bus.stall_cnt)
  );
endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: default 5-phase instance and a 3-phase/4-bit-counter instance.
module tb_phase_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic run = 1'b0, step = 1'b0, stall = 1'b0, flush = 1'b0;
  bit   sel = 1'b0;

  int passed = 0;
  int total  = 0;

  // Reference model state (instruction-level view of the sequencer)
  bit      m_act;
  int      m_ph;
  longint  m_ret, m_stl;

  always #5 clk = ~clk;

  phase_sequencer_if #(.NUM_PHASES(5), .CNT_W(32)) ifa ();
  phase_sequencer_if #(.NUM_PHASES(3), .CNT_W(4))  ifb ();

  assign ifa.run = run;  assign ifa.step = step;  assign ifa.stall = stall;  assign ifa.flush = flush;
  assign ifb.run = run;  assign ifb.step = step;  assign ifb.stall = stall;  assign ifb.flush = flush;

  phase_sequencer dut_a (.clk(clk), .rst(rst), .bus(ifa));
  phase_sequencer #(.NUM_PHASES(3), .STALL_MASK(3'b110), .CNT_W(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  function automatic int np();       return sel ? 3 : 5; endfunction
  function automatic int maskbits(); return sel ? 6 : 4; endfunction
  function automatic longint wmask(); return sel ? 64'hF : 64'hFFFF_FFFF; endfunction

  function automatic logic [63:0] o_en();   return sel ? 64'(ifb.phase_en)    : 64'(ifa.phase_en);    endfunction
  function automatic logic [63:0] o_idx();  return sel ? 64'(ifb.phase_idx)   : 64'(ifa.phase_idx);   endfunction
  function automatic logic [63:0] o_halt(); return sel ? 64'(ifb.halted)      : 64'(ifa.halted);      endfunction
  function automatic logic [63:0] o_done(); return sel ? 64'(ifb.cycle_done)  : 64'(ifa.cycle_done);  endfunction
  function automatic logic [63:0] o_ret();  return sel ? 64'(ifb.retired_cnt) : 64'(ifa.retired_cnt); endfunction
  function automatic logic [63:0] o_stl();  return sel ? 64'(ifb.stall_cnt)   : 64'(ifa.stall_cnt);   endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h (t=%0t sel=%0d)", tag, obs, exp, $time, sel);
  endtask

  function automatic bit m_hold();
    return m_act && stall && ((maskbits() >> m_ph) & 1) != 0;
  endfunction

  function automatic bit m_done();
    return m_act && !flush && !m_hold() && (m_ph == np() - 1);
  endfunction

  task automatic model_reset();
    m_act = 0; m_ph = 0; m_ret = 0; m_stl = 0;
  endtask

  // One clock of the instruction-cycle rules, applied to the inputs present at the edge.
  task automatic model_clock();
    if (!m_act) begin
      if (run || step) begin m_act = 1; m_ph = 0; end
    end else if (flush) begin
      m_ph = 0; m_act = run;
    end else if (m_hold()) begin
      m_stl = (m_stl + 1) & wmask();
    end else if (m_ph == np() - 1) begin
      m_ret = (m_ret + 1) & wmask();
      m_ph = 0; m_act = run;
    end else begin
      m_ph++;
    end
  endtask

  task automatic check_regs(input string where);
    chk({where, ".phase_en"},  o_en(),   m_act ? (64'd1 << m_ph) : 64'd0);
    chk({where, ".phase_idx"}, o_idx(),  m_act ? 64'(m_ph) : 64'd0);
    chk({where, ".halted"},    o_halt(), 64'(!m_act));
    chk({where, ".retired"},   o_ret(),  64'(m_ret));
    chk({where, ".stalls"},    o_stl(),  64'(m_stl));
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic cyc();
    #1;
    chk("cycle_done", o_done(), 64'(m_done()));
    @(posedge clk);
    model_clock();
    #1;
    check_regs("clk");
    @(negedge clk);
  endtask

  task automatic goto_phase(input int p);
    for (int i = 0; i < 40 && !(m_act && m_ph == p); i++) cyc();
    chk("reach_phase", o_idx(), 64'(p));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && m_act; i++) cyc();
    chk("reach_idle", o_halt(), 64'd1);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_regs("reset");
    chk("reset.cycle_done", o_done(), 64'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // Reset state, then free-run from release with defaults
    run = 1'b1;
    @(negedge clk);
    apply_reset();
    for (int i = 0; i < 16; i++) cyc();
    chk("three_cycles_retired", o_ret(), 64'd3);
    chk("phase0_after_wrap", o_en(), 64'b00001);

    // Stall held for 4 clocks in RRF, then stall in unmasked phases 1 and 3
    goto_phase(2);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    chk("rrf_held", o_en(), 64'b00100);
    stall = 1'b0;
    cyc();
    chk("stall_cnt4", o_stl(), 64'd4);
    goto_phase(1);
    stall = 1'b1; cyc(); stall = 1'b0;
    chk("no_hold_ph1", o_idx(), 64'd2);
    goto_phase(3);
    stall = 1'b1; cyc(); stall = 1'b0;
    chk("no_hold_ph3", o_idx(), 64'd4);

    // Run drops mid-cycle: current cycle completes, then single step with an ignored second step
    run = 1'b0;
    wait_idle();
    step = 1'b1; cyc(); step = 1'b0;
    goto_phase(2);
    step = 1'b1; cyc(); step = 1'b0;
    wait_idle();
    for (int i = 0; i < 3; i++) cyc();
    chk("step_stays_idle", o_halt(), 64'd1);

    // Flush in the last phase, then flush+stall in RRF
    run = 1'b1;
    goto_phase(4);
    flush = 1'b1; cyc(); flush = 1'b0;
    chk("flush_to_ph0", o_idx(), 64'd0);
    goto_phase(2);
    flush = 1'b1; stall = 1'b1; cyc(); flush = 1'b0; stall = 1'b0;
    chk("flush_stall_ph0", o_idx(), 64'd0);

    // Randomized control traffic against the model
    for (int i = 0; i < 300; i++) begin
      run   = ($urandom_range(0, 9) < 7);
      step  = ($urandom_range(0, 9) < 2);
      stall = ($urandom_range(0, 9) < 3);
      flush = ($urandom_range(0, 19) == 0);
      cyc();
    end
    run = 1'b1; step = 1'b0; stall = 1'b0; flush = 1'b0;

    // Asynchronous reset in the middle of DM phase
    goto_phase(3);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_regs("async_rst");
    chk("async_rst.cycle_done", o_done(), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc();
    chk("restart_ph0", o_en(), 64'b00001);

    // Second configuration: 3 phases, mask 3'b110, 4-bit counters
    sel = 1'b1;
    run = 1'b1;
    apply_reset();
    for (int i = 0; i < 52; i++) begin
      stall = m_act && (m_ph == 0);
      cyc();
    end
    stall = 1'b0;
    chk("wrap_retired", o_ret(), 64'd1);
    chk("ph0_stall_ignored", o_stl(), 64'd0);
    for (int i = 0; i < 200; i++) begin
      run   = ($urandom_range(0, 9) < 7);
      step  = ($urandom_range(0, 9) < 2);
      stall = ($urandom_range(0, 9) < 4);
      flush = ($urandom_range(0, 19) == 0);
      cyc();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Parametrised multi-phase cycle sequencer for the non-pipelined SimpleRISC datapath, generalising the fixed 5-phase controller (update PC, read IM, read RF, DM op, write RF).
- Emits one-hot phase enables to the datapath.
- Adds a per-phase stall mask, single-step and halt modes, flush, and retired/stall event counters for debug.

Parameters:
- NUM_PHASES, 5, number of phases per instruction cycle (>=2).
- STALL_MASK, 5'b00100, bit i=1 means phase i holds while stall=1. Width NUM_PHASES. The default is the RRF phase.
- CNT_W, 32, width of retired_cnt and stall_cnt.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- run  in  1  1 = free-run; 0 = halt at the end of the current instruction cycle.
- step  in  1  single-cycle pulse; starts exactly one instruction cycle when idle and run=0.
- stall  in  1  hold request; honoured only in phases with STALL_MASK bit set.
- flush  in  1  abort the current instruction cycle.
- phase_en  out  NUM_PHASES  one-hot phase enable; all-zero when idle.
- phase_idx  out  $clog2(NUM_PHASES)  current phase index; 0 when idle.
- cycle_done  out  1  high in the last phase on the clock where it advances (combinational).
- halted  out  1  1 when idle.
- retired_cnt  out  CNT_W  completed instruction cycles.
- stall_cnt  out  CNT_W  cycles spent held by stall.

Behaviour:
- Reset (rst=0, async):
  - active=0, phase_idx=0, phase_en=0, halted=1, counters=0.
  - Reset mid-cycle aborts immediately. There is no cycle_done and no counter update.
- Internal state:
  - active bit: IDLE / ACTIVE.
  - phase_idx register.
  - phase_en = active ? onehot(phase_idx) : 0.
  - halted = ~active.
- hold = active & stall & STALL_MASK[phase_idx].
- Priority per clock: flush > hold > advance.
- IDLE:
  - If run=1 or step=1, go to ACTIVE, phase 0 next clock. Latency from run/step to phase_en[0] is 1 clock.
  - Otherwise stay IDLE.
  - flush and stall are ignored in IDLE.
- ACTIVE, phase_idx < NUM_PHASES-1:
  - If hold, phase_idx unchanged and stall_cnt+1.
  - Otherwise phase_idx+1.
- ACTIVE, phase_idx = NUM_PHASES-1:
  - If hold, stay and stall_cnt+1.
  - Otherwise cycle_done=1 and retired_cnt+1. Next state: phase 0 if run=1, IDLE otherwise.
- Free-running throughput with no stall: one instruction per NUM_PHASES clocks, with no idle bubble between cycles.
- flush while ACTIVE:
  - Next state is phase 0 if run=1, IDLE otherwise.
  - No cycle_done and no retired_cnt increment, even if asserted in the last phase.
  - flush with stall in the same clock: flush wins, and stall_cnt does not increment.
- Single step:
  - step while ACTIVE is ignored (not queued).
  - run dropping mid-cycle does not stop the cycle. The current cycle completes, then the sequencer goes IDLE.
- Counters wrap modulo 2^CNT_W; no saturation.
- Stall in a masked-off phase has no effect, and that phase advances normally.
- Outputs are glitch-free registered decodes. The exception is cycle_done, which is a combinational function of registers and stall/flush.

Decomposition:
- Package phase_seq_pkg holds:
  - localparam defaults: NUM_PHASES=5; phase constants UPC=0, RIM=1, RRF=2, DM=3, WRF=4; STALL_MASK default.
  - function clog2_min1 for the phase_idx width (minimum 1).
- One sub-module, event_counter (CNT_W, inc, async active-low rst). It is instantiated twice, for retired_cnt and stall_cnt.

Test Plan:
1. Reset release with run=1, defaults:
   - phase_en must read 00000, 00001, 00010, 00100, 01000, 10000, 00001, ...
   - cycle_done is high every 5th clock.
   - retired_cnt = 3 after 3 full cycles.
2. stall=1 for 4 clocks while phase_idx=2:
   - phase_en holds at 00100 for 5 clocks total.
   - stall_cnt = 4.
   - stall asserted in phase 1 or 3 must not hold.
3. run=0 with a step pulse while idle:
   - Exactly phases 0-4 occur, then halted=1 and retired_cnt+1.
   - A second step during phase 2 is ignored.
4. flush during phase 4 with run=1:
   - Next clock phase_idx=0.
   - cycle_done never asserts and retired_cnt is unchanged.
   - flush+stall in phase 2 gives phase 0 next, and stall_cnt is unchanged.
5. NUM_PHASES=3, STALL_MASK=3'b110, CNT_W=4:
   - Free-run 17 cycles; retired_cnt wraps to 1.
   - stall in phase 0 is ignored.
6. rst asserted asynchronously mid-phase 3:
   - Outputs go to reset values immediately.
   - After release with run=1, the sequence restarts at phase 0 after 1 clock.
